// File: rtl/e_mdu_pkg.sv
// e_mdu shared definitions: op encodings, default latencies and op
// classification helpers used by the MDU datapath and control.
package e_mdu_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_md(logic [3:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

    function automatic logic is_mul(logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

endpackage

// File: rtl/e_mdu_if.sv
// E-stage MDU bus: op/operands from the D/E register, status and HI/LO back.
// slave = MDU side, master = pipeline side.
interface e_mdu_if;

    logic [3:0]  E_mdu_op;
    logic [31:0] E_rs_data;
    logic [31:0] E_rt_data;
    logic        E_start;
    logic        E_busy;
    logic [31:0] E_HI;
    logic [31:0] E_LO;
    logic [31:0] E_mdu_result;

    modport slave (
        input  E_mdu_op,
        input  E_rs_data,
        input  E_rt_data,
        output E_start,
        output E_busy,
        output E_HI,
        output E_LO,
        output E_mdu_result
    );

    modport master (
        output E_mdu_op,
        output E_rs_data,
        output E_rt_data,
        input  E_start,
        input  E_busy,
        input  E_HI,
        input  E_LO,
        input  E_mdu_result
    );

endinterface

// File: rtl/e_mdu_arith.sv
// MDU combinational datapath: {hi,lo} result of MULT/MULTU/DIV/DIVU.
// Ports: op_i, a_i (rs), b_i (rt), hi_i/lo_i (current HI/LO), res_o {hi,lo}.
module e_mdu_arith
    import e_mdu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [63:0] res_o
);

    logic [63:0] smul;
    logic [63:0] umul;
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] sq;
    logic [31:0] sr;
    logic        qneg;

    // Signed product: low 64 bits of the sign-extended operands.
    assign smul = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
    assign umul = {32'b0, a_i} * {32'b0, b_i};

    // Signed divide via magnitudes. |0x80000000| stays 0x80000000 as an
    // unsigned value, so 0x80000000 / -1 naturally yields LO=0x80000000,
    // HI=0 with no overflow trap.
    assign ua   = a_i[31] ? (~a_i + 32'd1) : a_i;
    assign ub   = b_i[31] ? (~b_i + 32'd1) : b_i;
    assign uq   = (ub == 32'd0) ? 32'd0 : ua / ub;
    assign ur   = (ub == 32'd0) ? 32'd0 : ua % ub;
    assign qneg = a_i[31] ^ b_i[31];
    assign sq   = qneg ? (~uq + 32'd1) : uq;
    assign sr   = a_i[31] ? (~ur + 32'd1) : ur;

    always_comb begin
        res_o = {hi_i, lo_i};
        unique case (1'b1)
            (op_i == OP_MULT):  res_o = smul;
            (op_i == OP_MULTU): res_o = umul;
            (op_i == OP_DIV):
                if (b_i != 32'd0) res_o = {sr, sq};
            (op_i == OP_DIVU):
                if (b_i != 32'd0) res_o = {a_i % b_i, a_i / b_i};
            default: res_o = {hi_i, lo_i};
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: fixed-latency MULT/DIV, HI/LO owner, MT/MF.
// Ports: clk, reset (async active-low), bus (e_mdu_if.slave).
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic    clk,
    input  logic    reset,
    e_mdu_if.slave  bus
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                          MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   phi_q, phi_d;
    logic [31:0]   plo_q, plo_d;
    logic [63:0]   arith_res;
    logic          start;

    e_mdu_arith u_arith (
        .op_i  (bus.E_mdu_op),
        .a_i   (bus.E_rs_data),
        .b_i   (bus.E_rt_data),
        .hi_i  (hi_q),
        .lo_i  (lo_q),
        .res_o (arith_res)
    );

    assign start = is_md(bus.E_mdu_op) && (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    {phi_d, plo_d} = arith_res;
                    cnt_d   = is_mul(bus.E_mdu_op) ?
                              CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                    state_d = S_BUSY;
                end else if (bus.E_mdu_op == OP_MTHI) begin
                    hi_d = bus.E_rs_data;
                end else if (bus.E_mdu_op == OP_MTLO) begin
                    lo_d = bus.E_rs_data;
                end
            end
            S_BUSY: begin
                // Ops arriving while busy (including MT) are dropped.
                if (cnt_q == CW'(1)) begin
                    hi_d    = phi_q;
                    lo_d    = plo_q;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
        end
    end

    assign bus.E_start      = start;
    assign bus.E_busy       = (state_q == S_BUSY);
    assign bus.E_HI         = hi_q;
    assign bus.E_LO         = lo_q;
    assign bus.E_mdu_result = (bus.E_mdu_op == OP_MFHI) ? hi_q :
                              (bus.E_mdu_op == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// e_mdu bench: directed scenarios plus random op stream, each cycle
// compared against a cycle-count/arith reference model.
module tb_e_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [3:0] NONE  = 4'd0;
    localparam logic [3:0] MULT  = 4'd1;
    localparam logic [3:0] MULTU = 4'd2;
    localparam logic [3:0] DIV   = 4'd3;
    localparam logic [3:0] DIVU  = 4'd4;
    localparam logic [3:0] MTHI  = 4'd5;
    localparam logic [3:0] MTLO  = 4'd6;
    localparam logic [3:0] MFHI  = 4'd7;
    localparam logic [3:0] MFLO  = 4'd8;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    e_mdu_if mif ();

    e_mdu #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] m_pend = '0;
    int          m_left = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference arithmetic in 64-bit integers; DIV overflow falls out of
    // the wider quotient, divide-by-zero keeps the old HI/LO.
    function automatic logic [63:0] ref_md(logic [3:0] op,
                                           logic [31:0] a, logic [31:0] b,
                                           logic [31:0] hi, logic [31:0] lo);
        longint sa, sb, q, r;
        longint unsigned ua, ub, uq, ur, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            MULT: begin
                q = sa * sb;
                return q;
            end
            MULTU: begin
                p = ua * ub;
                return p;
            end
            DIV: begin
                if (b == 32'd0) return {hi, lo};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            DIVU: begin
                if (b == 32'd0) return {hi, lo};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            default: return {hi, lo};
        endcase
    endfunction

    task automatic step(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        logic        ms;
        logic [31:0] mr;
        @(negedge clk);
        mif.E_mdu_op  = op;
        mif.E_rs_data = a;
        mif.E_rt_data = b;
        #1;
        ms = (op >= MULT) && (op <= DIVU) && (m_left == 0);
        mr = (op == MFHI) ? m_hi : (op == MFLO) ? m_lo : 32'd0;
        check("start", 32'(mif.E_start), 32'(ms));
        check("busy", 32'(mif.E_busy), 32'(m_left > 0));
        check("hi", mif.E_HI, m_hi);
        check("lo", mif.E_LO, m_lo);
        check("result", mif.E_mdu_result, mr);
        @(posedge clk);
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) {m_hi, m_lo} = m_pend;
        end else if (ms) begin
            m_pend = ref_md(op, a, b, m_hi, m_lo);
            m_left = (op <= MULTU) ? MC : DC;
        end else if (op == MTHI) begin
            m_hi = a;
        end else if (op == MTLO) begin
            m_lo = a;
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(NONE, $urandom, $urandom);
        #1;
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [3:0] rnd_op();
        int r;
        r = int'($urandom_range(0, 15));
        if (r < 8) return 4'(r + 1);
        if (r == 8) return NONE;
        return 4'($urandom_range(0, 15));
    endfunction

    initial begin
        mif.E_mdu_op  = NONE;
        mif.E_rs_data = '0;
        mif.E_rt_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(mif.E_busy), 32'd0);
        check("rst_hi", mif.E_HI, 32'd0);
        check("rst_lo", mif.E_LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        step(MULT, 32'hFFFF_FFFF, 32'd2);
        idle(MC);
        check("mult_hi", mif.E_HI, 32'hFFFF_FFFF);
        check("mult_lo", mif.E_LO, 32'hFFFF_FFFE);

        step(MULTU, 32'hFFFF_FFFF, 32'd2);
        idle(MC);
        check("multu_hi", mif.E_HI, 32'h0000_0001);
        check("multu_lo", mif.E_LO, 32'hFFFF_FFFE);

        step(DIV, 32'hFFFF_FFF9, 32'd2);
        idle(DC);
        check("div_hi", mif.E_HI, 32'hFFFF_FFFF);
        check("div_lo", mif.E_LO, 32'hFFFF_FFFD);

        step(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(DC);
        check("ovf_hi", mif.E_HI, 32'h0000_0000);
        check("ovf_lo", mif.E_LO, 32'h8000_0000);

        step(DIVU, 32'd5, 32'd0);
        idle(DC);
        check("dz_hi", mif.E_HI, 32'h0000_0000);
        check("dz_lo", mif.E_LO, 32'h8000_0000);

        step(MTHI, 32'h0000_1234, 32'd0);
        #1;
        check("mthi", mif.E_HI, 32'h0000_1234);

        step(MULT, 32'd3, 32'd4);
        step(MTLO, 32'hDEAD_BEEF, 32'd0);
        idle(MC - 1);
        check("mtlo_ign", mif.E_LO, 32'd12);
        step(MFLO, 32'd0, 32'd0);
        step(MFHI, 32'd0, 32'd0);

        // Asynchronous reset in the middle of a divide.
        step(DIV, 32'd100, 32'd7);
        step(NONE, 32'd0, 32'd0);
        step(NONE, 32'd0, 32'd0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_busy", 32'(mif.E_busy), 32'd0);
        check("arst_hi", mif.E_HI, 32'd0);
        check("arst_lo", mif.E_LO, 32'd0);
        m_hi   = '0;
        m_lo   = '0;
        m_left = 0;
        @(posedge clk);
        #2;
        reset = 1'b1;

        step(MULT, 32'd6, 32'd7);
        idle(MC);
        check("post_rst", mif.E_LO, 32'd42);

        for (int i = 0; i < 3000; i++) step(rnd_op(), rnd_opnd(), rnd_opnd());
        idle(DC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
